// File: rtl/conditional_split_if.sv
// Bus bundle for conditional_split: run control, config, selector/data in, split outputs.
interface conditional_split_if #(
  parameter int unsigned DATA_W = 32
);
  logic              running;
  logic              run;
  logic [DATA_W-1:0] delay0;
  logic [DATA_W-1:0] length;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic              done;

  modport master (
    output running, run, delay0, length, in0, in1,
    input  out0, out1, out2, out3, done
  );

  modport slave (
    input  running, run, delay0, length, in0, in1,
    output out0, out1, out2, out3, done
  );
endinterface

// File: rtl/conditional_split.sv
// Versat conditional split: steers in1 to out0 (in0[0]=1) or out1 (in0[0]=0).
// Branch counters out2/out3 exist only when CONDITIONAL_SPLIT_COUNT_EN is defined.
module conditional_split #(
  parameter int unsigned DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  conditional_split_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StActive} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] delay_q, delay_d;
  logic [DATA_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] out0_q, out0_d;
  logic [DATA_W-1:0] out1_q, out1_d;
  logic              consume;
  logic              sel;

  assign sel = bus.in0[0];

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    remain_d = remain_q;
    out0_d   = out0_q;
    out1_d   = out1_q;
    consume  = 1'b0;
    if (bus.run) begin
      state_d  = StDelay;
      delay_d  = bus.delay0;
      remain_d = bus.length;
    end else if (bus.running) begin
      unique case (state_q)
        // An expired delay consumes on the same edge so the first sample lands at E+1+delay0.
        StDelay: begin
          if (delay_q != '0) begin
            delay_d = delay_q - DATA_W'(1);
          end else if (remain_q == '0) begin
            state_d = StIdle;
          end else begin
            consume = 1'b1;
          end
        end
        StActive: consume = 1'b1;
        default: ;
      endcase
      if (consume) begin
        remain_d = remain_q - DATA_W'(1);
        state_d  = (remain_q == DATA_W'(1)) ? StIdle : StActive;
        if (sel) begin
          out0_d = bus.in1;
        end else begin
          out1_d = bus.in1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      delay_q  <= '0;
      remain_q <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      remain_q <= remain_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
    end
  end

`ifdef CONDITIONAL_SPLIT_COUNT_EN
  logic [DATA_W-1:0] cnt0_q, cnt0_d;
  logic [DATA_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (bus.run) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (consume) begin
      if (sel) begin
        cnt0_d = cnt0_q + DATA_W'(1);
      end else begin
        cnt1_d = cnt1_q + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.out2 = cnt0_q;
  assign bus.out3 = cnt1_q;
`else
  assign bus.out2 = '0;
  assign bus.out3 = '0;
`endif

  assign bus.out0 = out0_q;
  assign bus.out1 = out1_q;
  assign bus.done = (state_q == StIdle);

endmodule

// File: doc/conditional_split.md
# conditional_split

Versat functional unit that routes one data stream to one of two outputs under control of a per-sample selector. It is the inverse of the two-input conditional select unit. `in1` is steered to `out0` when the selector is true, otherwise to `out1`. It sits in the Versat datapath between a memory/generator unit and two downstream consumers, with a configurable start delay and sample length. Optional per-branch counters report how many samples took each path.

## Interface
- `DATA_W`, 32, width of data, outputs and counters.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `running`  in  1  accelerator running; samples are consumed only while high.
- `run`  in  1  single-cycle start pulse; (re)starts a run.
- `delay0`  in  DATA_W  config: cycles to wait after `run` before the first sample.
- `length`  in  DATA_W  config: number of samples to process per run.
- `in0`  in  DATA_W  selector; only bit 0 is used.
- `in1`  in  DATA_W  data sample.
- `out0`  out  DATA_W  last sample with `in0[0]`=1; versat latency 1.
- `out1`  out  DATA_W  last sample with `in0[0]`=0; versat latency 1.
- `out2`  out  DATA_W  count of samples routed to `out0` this run.
- `out3`  out  DATA_W  count of samples routed to `out1` this run.
- `done`  out  1  high when idle or finished; low while a run is in progress.

## Operation
- FSM states: IDLE, DELAY, ACTIVE.
- Reset: state IDLE; `out0`..`out3` = 0; `done` = 1; internal delay and length counters = 0.
- `run`=1 in any state, including mid-run:
  - Latch `delay0` into the delay counter and `length` into the remaining counter.
  - Clear `out2` and `out3`; set `done` = 0.
  - Go to DELAY.
  - `out0` and `out1` keep their values.
- DELAY:
  - While `running`=1 and delay counter > 0, decrement it.
  - When the counter is 0, go to ACTIVE. If remaining = 0, go to IDLE with `done` = 1 instead.
  - While `running`=0, nothing changes.
- ACTIVE, each cycle with `running`=1, consume one sample:
  - If `in0[0]`=1: `out0` <= `in1` and `out2` += 1; `out1` holds.
  - Otherwise: `out1` <= `in1` and `out3` += 1; `out0` holds.
  - Decrement remaining. When it reaches 0, go to IDLE and set `done` = 1 on that same edge.
- ACTIVE with `running`=0: freeze; no sample is consumed and no output changes.
- IDLE: outputs hold; `in0`/`in1` are ignored.
- Arithmetic: counters are DATA_W unsigned and wrap modulo 2^DATA_W. `out2` + `out3` equals the number of samples consumed.
- Only `in0[0]` is decoded; all other selector bits are ignored.

## Timing
- `run` is sampled at edge E:
  - DELAY spans the next `delay0` running cycles.
  - The first sample is consumed at edge E+1+`delay0` (`running` held high).
- Latency is 1 cycle: a sample present at consuming edge k is visible on `out0`/`out1` after edge k.
- `done` falls after edge E. It rises after the edge consuming sample number `length`, i.e. edge E+`delay0`+`length` with continuous `running`.
- `delay0`=0 and `length`=0: `done` returns high after edge E+1; no outputs change.
- `run` during ACTIVE restarts immediately. The sample present at that edge is not consumed.
- Asynchronous `rst` mid-run forces the reset values immediately, independent of `clk`.

## Configuration
- `CONDITIONAL_SPLIT_COUNT_EN` defined: the branch counters are built and `out2`/`out3` behave as above.
- `CONDITIONAL_SPLIT_COUNT_EN` undefined: no counter registers exist; `out2` and `out3` are constant 0.
- The FSM, `done`, `out0` and `out1` are identical in both builds.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → `out0`..`out3` = 0 and `done` = 1 immediately.
- Basic split: `delay0`=0, `length`=4, `running`=1, pulse `run`, then drive (sel,data) = (1,0xA),(0,0xB),(1,0xC),(0,0xD) → final `out0`=0xC, `out1`=0xD, `out2`=2, `out3`=2; `done` high 4 cycles after the `run` edge.
- Delay: `delay0`=3, `length`=1 → the sample present 4 cycles after the `run` edge is consumed; earlier samples are ignored.
- Running stall: `length`=3 with `running` low for 2 cycles mid-ACTIVE → exactly 3 samples consumed; `done` rises 2 cycles later than without the stall.
- Restart: pulse `run` during ACTIVE with `length`=2 → counters clear, exactly 2 new samples are consumed, and prior `out0`/`out1` values hold until overwritten.
- Build without `CONDITIONAL_SPLIT_COUNT_EN`: repeat the basic split → `out2`=`out3`=0 throughout; `out0`/`out1`/`done` match the counter build.
